// File: rtl/ps2_seg_vga_ctrl_if.sv
// Pixel-side bundle between the VGA timing core and the frame buffer / DAC pins.
interface ps2_seg_vga_ctrl_if;
  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (input vga_data,
                  output h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b);
  modport slave  (output vga_data,
                  input h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b);
endinterface

// File: rtl/ps2_seg_vga_ctrl.sv
// Board I/O core: 640x480@60 VGA timing, PS/2 set-2 keyboard receiver and
// an 8-digit seven-segment readout of the held key, its ASCII and a press count.
module ps2_seg_vga_ctrl #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int PS2_SYNC = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_seg_vga_ctrl_if.master vga,
  output logic [7:0]         o_seg0,
  output logic [7:0]         o_seg1,
  output logic [7:0]         o_seg2,
  output logic [7:0]         o_seg3,
  output logic [7:0]         o_seg4,
  output logic [7:0]         o_seg5,
  output logic [7:0]         o_seg6,
  output logic [7:0]         o_seg7
);
  localparam logic [9:0] H_SYNC_E = 10'd96;
  localparam logic [9:0] H_ACT_B  = 10'd144;
  localparam logic [9:0] H_ACT_E  = 10'd784;
  localparam logic [9:0] V_SYNC_E = 10'd2;
  localparam logic [9:0] V_ACT_B  = 10'd35;
  localparam logic [9:0] V_ACT_E  = 10'd515;

  // ---------------- VGA timing ----------------
  logic [9:0] x, y;
  logic       act;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (x == 10'(H_TOTAL - 1)) begin
      x <= '0;
      y <= (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  assign act        = (x >= H_ACT_B) && (x < H_ACT_E) && (y >= V_ACT_B) && (y < V_ACT_E);
  assign vga.valid  = act;
  assign vga.hsync  = (x >= H_SYNC_E);
  assign vga.vsync  = (y >= V_SYNC_E);
  assign vga.h_addr = act ? x - H_ACT_B : '0;
  assign vga.v_addr = act ? y - V_ACT_B : '0;
  assign vga.vga_r  = act ? vga.vga_data[23:16] : '0;
  assign vga.vga_g  = act ? vga.vga_data[15:8]  : '0;
  assign vga.vga_b  = act ? vga.vga_data[7:0]   : '0;

  // ---------------- PS/2 receiver ----------------
  logic [PS2_SYNC-1:0] kc_sync, kd_sync;
  logic                kc_prev, kc_fall, kd_s;
  logic [9:0]          sh;
  logic [3:0]          bcnt;
  logic                code_valid;
  logic [7:0]          code;

  assign kd_s    = kd_sync[PS2_SYNC-1];
  assign kc_fall = kc_prev & ~kc_sync[PS2_SYNC-1];

  // Synchronizers reset to the idle-high line level so release makes no edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kc_sync <= '1;
      kd_sync <= '1;
      kc_prev <= 1'b1;
    end else begin
      kc_sync <= {kc_sync[PS2_SYNC-2:0], ps2_clk};
      kd_sync <= {kd_sync[PS2_SYNC-2:0], ps2_data};
      kc_prev <= kc_sync[PS2_SYNC-1];
    end
  end

  // sh fills from the top: after ten bits sh[0]=start, sh[8:1]=data, sh[9]=parity.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh         <= '0;
      bcnt       <= '0;
      code_valid <= 1'b0;
      code       <= '0;
    end else begin
      code_valid <= 1'b0;
      if (kc_fall) begin
        if (bcnt == 4'd10) begin
          bcnt <= '0;
          if (!sh[0] && kd_s && (^sh[9:1])) begin
            code_valid <= 1'b1;
            code       <= sh[8:1];
          end
        end else begin
          sh   <= {kd_s, sh[9:1]};
          bcnt <= bcnt + 4'd1;
        end
      end
    end
  end

  // ---------------- key decode ----------------
  typedef enum logic {ST_MAKE, ST_BREAK} dec_state_t;
  dec_state_t state, state_nx;
  logic       mk, rel, held, upd;
  logic [7:0] cur, cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_MAKE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mk       = 1'b0;
    rel      = 1'b0;
    if (code_valid && code != 8'hE0) begin
      if (code == 8'hF0) begin
        state_nx = ST_BREAK;
      end else if (state == ST_BREAK) begin
        state_nx = ST_MAKE;
        rel      = 1'b1;
      end else begin
        mk = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held <= 1'b0;
      cur  <= '0;
      cnt  <= '0;
      upd  <= 1'b0;
    end else begin
      upd <= code_valid;
      if (rel) held <= 1'b0;
      if (mk) begin
        if (!held) cnt <= cnt + 8'd1;
        held <= 1'b1;
        cur  <= code;
      end
    end
  end

  // ---------------- seven-segment ----------------
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Bit 8 flags a mapped code; lower byte is the lowercase ASCII value.
  function automatic logic [8:0] ascii_of(input logic [7:0] c);
    case (c)
      8'h45: return 9'h130;  8'h16: return 9'h131;  8'h1E: return 9'h132;  8'h26: return 9'h133;
      8'h25: return 9'h134;  8'h2E: return 9'h135;  8'h36: return 9'h136;  8'h3D: return 9'h137;
      8'h3E: return 9'h138;  8'h46: return 9'h139;
      8'h1C: return 9'h161;  8'h32: return 9'h162;  8'h21: return 9'h163;  8'h23: return 9'h164;
      8'h24: return 9'h165;  8'h2B: return 9'h166;  8'h34: return 9'h167;  8'h33: return 9'h168;
      8'h43: return 9'h169;  8'h3B: return 9'h16A;  8'h42: return 9'h16B;  8'h4B: return 9'h16C;
      8'h3A: return 9'h16D;  8'h31: return 9'h16E;  8'h44: return 9'h16F;  8'h4D: return 9'h170;
      8'h15: return 9'h171;  8'h2D: return 9'h172;  8'h1B: return 9'h173;  8'h2C: return 9'h174;
      8'h3C: return 9'h175;  8'h2A: return 9'h176;  8'h1D: return 9'h177;  8'h22: return 9'h178;
      8'h35: return 9'h179;  8'h1A: return 9'h17A;
      default: return 9'h000;
    endcase
  endfunction

  logic [5:0][7:0] seg_q;
  logic [8:0]      asc;

  assign asc = ascii_of(cur);

  // Digits stay blank after reset until the first decoded code arrives.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_q <= '1;
    end else if (upd) begin
      seg_q[0] <= held ? hex7(cur[3:0]) : 8'hFF;
      seg_q[1] <= held ? hex7(cur[7:4]) : 8'hFF;
      seg_q[2] <= (held && asc[8]) ? hex7(asc[3:0]) : 8'hFF;
      seg_q[3] <= (held && asc[8]) ? hex7(asc[7:4]) : 8'hFF;
      seg_q[4] <= hex7(cnt[3:0]);
      seg_q[5] <= hex7(cnt[7:4]);
    end
  end

  assign o_seg0 = seg_q[0];
  assign o_seg1 = seg_q[1];
  assign o_seg2 = seg_q[2];
  assign o_seg3 = seg_q[3];
  assign o_seg4 = seg_q[4];
  assign o_seg5 = seg_q[5];
  assign o_seg6 = 8'hFF;
  assign o_seg7 = 8'hFF;
endmodule

// File: tb/tb_ps2_seg_vga_ctrl.sv
// Bench for ps2_seg_vga_ctrl: VGA line/frame timing sweep, table of PS/2 frames
// with expected digit patterns through a queue, and a mid-frame reset sequence.
module tb_ps2_seg_vga_ctrl;
  localparam int HALF = 8;

  logic clk = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic [63:0] segs;
  int checks = 0, passed = 0;

  ps2_seg_vga_ctrl_if vif();

  ps2_seg_vga_ctrl dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .vga(vif),
    .o_seg0(s0), .o_seg1(s1), .o_seg2(s2), .o_seg3(s3),
    .o_seg4(s4), .o_seg5(s5), .o_seg6(s6), .o_seg7(s7)
  );

  assign segs = {s7, s6, s5, s4, s3, s2, s1, s0};

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic [1:0]  err;   // 0 good, 1 bad parity, 2 bad stop
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl[22];
  logic [63:0] sb_q[$];

  function automatic logic [63:0] sv(input logic [7:0] a5, a4, a3, a2, a1, a0);
    return {16'hFFFF, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic send_bits(input logic [7:0] c, input logic [1:0] err, input int nbits);
    logic [10:0] f;
    f = {(err == 2'd2) ? 1'b0 : 1'b1, (err == 2'd1) ? (^c) : ~(^c), c, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic expect_segs(input string name);
    logic [63:0] e;
    repeat (20) @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty, got %h", name, segs);
    end else begin
      e = sb_q.pop_front();
      chk(name, segs, e);
    end
  endtask

  initial begin
    int   hs_lo, va_cnt, bad_sync, bad_addr, bad_rgb;
    logic exp_va;

    tbl[0]  = '{8'h1C, 2'd0, sv(8'hC0, 8'hF9, 8'h82, 8'hF9, 8'hF9, 8'hC6)};
    tbl[1]  = '{8'hF0, 2'd0, sv(8'hC0, 8'hF9, 8'h82, 8'hF9, 8'hF9, 8'hC6)};
    tbl[2]  = '{8'h1C, 2'd0, sv(8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    tbl[3]  = '{8'h16, 2'd0, sv(8'hC0, 8'hA4, 8'hB0, 8'hF9, 8'hF9, 8'h82)};
    tbl[4]  = '{8'h16, 2'd0, sv(8'hC0, 8'hA4, 8'hB0, 8'hF9, 8'hF9, 8'h82)};
    tbl[5]  = '{8'h16, 2'd0, sv(8'hC0, 8'hA4, 8'hB0, 8'hF9, 8'hF9, 8'h82)};
    tbl[6]  = '{8'hF0, 2'd0, sv(8'hC0, 8'hA4, 8'hB0, 8'hF9, 8'hF9, 8'h82)};
    tbl[7]  = '{8'h16, 2'd0, sv(8'hC0, 8'hA4, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    tbl[8]  = '{8'h1C, 2'd1, sv(8'hC0, 8'hA4, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    tbl[9]  = '{8'h1C, 2'd0, sv(8'hC0, 8'hB0, 8'h82, 8'hF9, 8'hF9, 8'hC6)};
    tbl[10] = '{8'hE0, 2'd0, sv(8'hC0, 8'hB0, 8'h82, 8'hF9, 8'hF9, 8'hC6)};
    tbl[11] = '{8'hF0, 2'd0, sv(8'hC0, 8'hB0, 8'h82, 8'hF9, 8'hF9, 8'hC6)};
    tbl[12] = '{8'h1C, 2'd0, sv(8'hC0, 8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    tbl[13] = '{8'h76, 2'd0, sv(8'hC0, 8'h99, 8'hFF, 8'hFF, 8'hF8, 8'h82)};
    tbl[14] = '{8'h5A, 2'd0, sv(8'hC0, 8'h99, 8'hFF, 8'hFF, 8'h92, 8'h88)};
    tbl[15] = '{8'h45, 2'd2, sv(8'hC0, 8'h99, 8'hFF, 8'hFF, 8'h92, 8'h88)};
    tbl[16] = '{8'hF0, 2'd0, sv(8'hC0, 8'h99, 8'hFF, 8'hFF, 8'h92, 8'h88)};
    tbl[17] = '{8'h5A, 2'd0, sv(8'hC0, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    tbl[18] = '{8'h45, 2'd0, sv(8'hC0, 8'h92, 8'hB0, 8'hC0, 8'h99, 8'h92)};
    tbl[19] = '{8'hF0, 2'd0, sv(8'hC0, 8'h92, 8'hB0, 8'hC0, 8'h99, 8'h92)};
    tbl[20] = '{8'h45, 2'd0, sv(8'hC0, 8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    tbl[21] = '{8'h1A, 2'd0, sv(8'hC0, 8'h82, 8'hF8, 8'h88, 8'hF9, 8'h88)};

    vif.vga_data = 24'h123456;
    repeat (4) @(negedge clk);
    chk("reset_segs", segs, {64{1'b1}});
    chk("reset_vga", {41'd0, vif.hsync, vif.vsync, vif.valid, vif.h_addr, vif.v_addr}, 64'd0);

    // VGA sweep from x=0,y=0 through the first two active lines
    resetn = 1'b1;
    #1;
    bad_sync = 0; bad_addr = 0; bad_rgb = 0;
    for (int ly = 0; ly < 37; ly++) begin
      hs_lo = 0; va_cnt = 0;
      for (int lx = 0; lx < 800; lx++) begin
        exp_va = (lx >= 144) && (lx < 784) && (ly >= 35);
        if (!vif.hsync) hs_lo++;
        if (vif.valid) va_cnt++;
        if (vif.valid !== exp_va || vif.hsync !== (lx >= 96) || vif.vsync !== (ly >= 2)) bad_sync++;
        if (exp_va) begin
          if (vif.h_addr !== 10'(lx - 144) || vif.v_addr !== 10'(ly - 35)) bad_addr++;
          if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 24'h123456) bad_rgb++;
        end else begin
          if (vif.h_addr !== 10'd0 || vif.v_addr !== 10'd0) bad_addr++;
          if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 24'h0) bad_rgb++;
        end
        if (lx == 144 && ly == 35) chk("addr_origin", {44'd0, vif.h_addr, vif.v_addr}, 64'd0);
        if (lx == 200 && ly == 1)  chk("vsync_line1", 64'(vif.vsync), 64'd0);
        if (lx == 200 && ly == 2)  chk("vsync_line2", 64'(vif.vsync), 64'd1);
        @(negedge clk);
      end
      if (ly == 0)  chk("hsync_low_l0", 64'(hs_lo), 64'd96);
      if (ly == 36) chk("hsync_low_l36", 64'(hs_lo), 64'd96);
      if (ly == 34) chk("valid_cnt_l34", 64'(va_cnt), 64'd0);
      if (ly == 35) chk("valid_cnt_l35", 64'(va_cnt), 64'd640);
      if (ly == 36) chk("valid_cnt_l36", 64'(va_cnt), 64'd640);
    end
    chk("sync_valid_track", 64'(bad_sync), 64'd0);
    chk("addr_track", 64'(bad_addr), 64'd0);
    chk("rgb_track", 64'(bad_rgb), 64'd0);

    // PS/2 frame table
    for (int i = 0; i < 22; i++) begin
      send_bits(tbl[i].code, tbl[i].err, 11);
      sb_q.push_back(tbl[i].exp);
      expect_segs($sformatf("frame%0d_%h", i, tbl[i].code));
    end

    // reset in the middle of a frame
    send_bits(8'h1C, 2'd0, 4);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midreset_segs", segs, {64{1'b1}});
    chk("midreset_vga", {41'd0, vif.hsync, vif.vsync, vif.valid, vif.h_addr, vif.v_addr}, 64'd0);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", segs, {64{1'b1}});
    send_bits(8'h1C, 2'd0, 11);
    sb_q.push_back(sv(8'hC0, 8'hF9, 8'h82, 8'hF9, 8'hF9, 8'hC6));
    expect_segs("post_reset_frame");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
